tri_axi_packer: RTL and testbench



---
 rtl/tri_axi_packer.sv | 143 ++++++++++++++
 tb/tb_tri_axi_packer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_axi_packer.sv
// AXI4-Lite write slave that gathers six words per triangle into shadow
// registers and commits the 192-bit record to a valid/ready output slot.
module tri_axi_packer #(
   parameter int unsigned C_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_AXI_ADDR_WIDTH = 14
) (
   input  logic                          axi_aclk,
   input  logic                          axi_aresetn,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
   input  logic                          axi_awvalid,
   output logic                          axi_awready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
   input  logic                          axi_wvalid,
   output logic                          axi_wready,
   output logic [1:0]                    axi_bresp,
   output logic                          axi_bvalid,
   input  logic                          axi_bready,
   output logic [6*C_AXI_DATA_WIDTH-1:0] tri_data,
   output logic                          tri_valid,
   input  logic                          tri_ready,
   output logic [15:0]                   tri_count,
   output logic                          busy
);

   localparam int unsigned DW = C_AXI_DATA_WIDTH;

   typedef enum logic [1:0] {StIdle, StWrite, StStall, StResp} state_e;

   state_e              state_q, state_d;
   logic                aw_held_q, w_held_q;
   logic [2:0]          idx_q;
   logic [DW-1:0]       wdata_q;
   logic [4:0][DW-1:0]  shadow_q;
   logic [6*DW-1:0]     tri_data_q;
   logic                tri_valid_q;
   logic [15:0]         tri_count_q;
   logic [1:0]          bresp_q;
   logic                aw_hs, w_hs, slot_full, commit;
   logic                unused_addr_bits;

   // Only the word index is decoded; the remaining address bits are don't-care.
   assign unused_addr_bits = ^{axi_awaddr[C_AXI_ADDR_WIDTH-1:5], axi_awaddr[1:0]};

   assign aw_hs     = axi_awvalid & axi_awready;
   assign w_hs      = axi_wvalid & axi_wready;
   assign slot_full = tri_valid_q & ~tri_ready;
   // A commit either goes straight in, or waits in StStall for the slot to drain.
   assign commit    = ((state_q == StWrite) && (idx_q == 3'd5) && !slot_full) ||
                      ((state_q == StStall) && tri_ready);

   assign axi_bresp = bresp_q;
   assign tri_data  = tri_data_q;
   assign tri_valid = tri_valid_q;
   assign tri_count = tri_count_q;

   // State register
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) state_d = StWrite;
         StWrite: state_d = ((idx_q == 3'd5) && slot_full) ? StStall : StResp;
         StStall: if (tri_ready) state_d = StResp;
         StResp:  if (axi_bready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Handshake and status outputs
   always_comb begin
      axi_awready = 1'b0;
      axi_wready  = 1'b0;
      axi_bvalid  = 1'b0;
      busy        = 1'b0;
      unique case (state_q)
         StIdle: begin
            axi_awready = ~aw_held_q;
            axi_wready  = ~w_held_q;
         end
         StStall: busy       = 1'b1;
         StResp:  axi_bvalid = 1'b1;
         default: ;
      endcase
   end

   // Address/data capture; AW and W may arrive in either order
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            idx_q     <= axi_awaddr[4:2];
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= axi_wdata;
         end
         if ((state_q == StResp) && axi_bready) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end
      end
   end

   // Shadow registers, write response code and the output record slot
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         shadow_q    <= '0;
         bresp_q     <= 2'b00;
         tri_data_q  <= '0;
         tri_valid_q <= 1'b0;
         tri_count_q <= '0;
      end else begin
         if (state_q == StWrite) begin
            bresp_q <= (idx_q[2:1] == 2'b11) ? 2'b10 : 2'b00;
            for (int i = 0; i < 5; i++) begin
               if (idx_q == 3'(i)) shadow_q[i] <= wdata_q;
            end
         end
         // A drain and a commit on the same edge keep the slot occupied.
         if (commit) begin
            tri_data_q  <= {wdata_q, shadow_q};
            tri_valid_q <= 1'b1;
            tri_count_q <= tri_count_q + 16'd1;
         end else if (tri_valid_q && tri_ready) begin
            tri_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tri_axi_packer.sv
// Scoreboard bench for tri_axi_packer: stimulus pushes expected B responses and
// triangle records; a monitor pops them as the DUT presents them.
module tb_tri_axi_packer;

   logic         axi_aclk = 1'b0;
   logic         axi_aresetn;
   logic [13:0]  axi_awaddr;
   logic         axi_awvalid, axi_awready;
   logic [31:0]  axi_wdata;
   logic         axi_wvalid, axi_wready;
   logic [1:0]   axi_bresp;
   logic         axi_bvalid, axi_bready;
   logic [191:0] tri_data;
   logic         tri_valid, tri_ready;
   logic [15:0]  tri_count;
   logic         busy;

   typedef struct {
      logic [191:0] data;
      logic [15:0]  count;
   } rec_t;

   int           total = 0;
   int           bad = 0;
   logic [1:0]   bq[$];
   rec_t         rq[$];
   logic [31:0]  sh[5];
   logic [15:0]  cnt_m;
   logic [191:0] last_rec;
   logic [191:0] rec_a;

   localparam logic [191:0] RED_REC =
      192'h0000068D_00E00032_00780028_00320078_008C0032_00140028;
   logic [31:0] red_w[6] = '{32'h00140028, 32'h008C0032, 32'h00320078,
                             32'h00780028, 32'h00E00032, 32'h0000068D};
   logic [31:0] a_w[6]   = '{32'h00100005, 32'h00050010, 32'h00200010,
                             32'h00100020, 32'h00FF0010, 32'h00001000};
   logic [31:0] b_w[6]   = '{32'h00300007, 32'h00090030, 32'h00400030,
                             32'h00300040, 32'h00AA0030, 32'h00002000};

   tri_axi_packer #(
      .C_AXI_DATA_WIDTH (32),
      .C_AXI_ADDR_WIDTH (14)
   ) dut (
      .axi_aclk    (axi_aclk),
      .axi_aresetn (axi_aresetn),
      .axi_awaddr  (axi_awaddr),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_wdata   (axi_wdata),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .axi_bresp   (axi_bresp),
      .axi_bvalid  (axi_bvalid),
      .axi_bready  (axi_bready),
      .tri_data    (tri_data),
      .tri_valid   (tri_valid),
      .tri_ready   (tri_ready),
      .tri_count   (tri_count),
      .busy        (busy)
   );

   always #5 axi_aclk = ~axi_aclk;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue AW and W (each starting at its own cycle offset) and update the model.
   task automatic do_handshake(input logic [13:0] addr, input logic [31:0] data,
                               input int aw_start, input int w_start, output bit ok);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      int c = 0;
      int idx;
      while (!(aw_done && w_done) && c < 40) begin
         axi_awaddr  = addr;
         axi_wdata   = data;
         axi_awvalid = (c >= aw_start) && !aw_done;
         axi_wvalid  = (c >= w_start) && !w_done;
         @(negedge axi_aclk);
         if (aw_done && !w_done) begin
            check("awready_after_aw", axi_awready, 1'b0);
            check("wready_while_waiting", axi_wready, 1'b1);
         end
         if (w_done && !aw_done) begin
            check("wready_after_w", axi_wready, 1'b0);
            check("awready_while_waiting", axi_awready, 1'b1);
         end
         if (axi_awvalid && axi_awready) aw_done = 1'b1;
         if (axi_wvalid && axi_wready) w_done = 1'b1;
         @(posedge axi_aclk);
         #1;
         c++;
      end
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      ok = aw_done && w_done;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL handshake_timeout: got no handshake expected AW and W accepted");
         return;
      end
      idx = int'(addr[4:2]);
      bq.push_back((idx >= 6) ? 2'b10 : 2'b00);
      if (idx < 5) begin
         sh[idx] = data;
      end else if (idx == 5) begin
         rec_t r;
         cnt_m++;
         last_rec = {data, sh[4], sh[3], sh[2], sh[1], sh[0]};
         r.data   = last_rec;
         r.count  = cnt_m;
         rq.push_back(r);
      end
   endtask

   // Full write with latency checks; expects no stall.
   task automatic axi_write(input logic [13:0] addr, input logic [31:0] data,
                            input int aw_start, input int w_start);
      bit ok;
      do_handshake(addr, data, aw_start, w_start, ok);
      if (!ok) return;
      @(negedge axi_aclk);
      check("bvalid_early", axi_bvalid, 1'b0);
      @(negedge axi_aclk);
      check("bvalid_rise", axi_bvalid, 1'b1);
      if (addr[4:2] == 3'd5) begin
         check("commit_valid", tri_valid, 1'b1);
         check("commit_data", tri_data, last_rec);
         check("commit_count", tri_count, cnt_m);
      end
      if (axi_bready) begin
         @(posedge axi_aclk);
         #1;
      end
   endtask

   // Monitor: pops expectations whenever the DUT completes a B or record transfer
   initial begin
      logic [1:0] eb;
      rec_t       er;
      forever begin
         @(negedge axi_aclk);
         if (axi_aresetn) begin
            if (axi_bvalid && axi_bready) begin
               if (bq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL b_unexpected: got bresp %b expected no response", axi_bresp);
               end else begin
                  eb = bq.pop_front();
                  check("bresp", axi_bresp, eb);
               end
            end
            if (tri_valid && tri_ready) begin
               if (rq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rec_unexpected: got %h expected no record", tri_data);
               end else begin
                  er = rq.pop_front();
                  check("rec_data", tri_data, er.data);
                  check("rec_count", tri_count, er.count);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1);
   end

   initial begin
      bit ok;
      axi_aresetn = 1'b0;
      axi_awaddr  = '0;
      axi_awvalid = 1'b0;
      axi_wdata   = '0;
      axi_wvalid  = 1'b0;
      axi_bready  = 1'b1;
      tri_ready   = 1'b1;
      cnt_m       = '0;
      last_rec    = '0;
      rec_a       = '0;
      for (int i = 0; i < 5; i++) sh[i] = '0;

      #12;
      check("rst_awready", axi_awready, 1'b1);
      check("rst_wready", axi_wready, 1'b1);
      check("rst_bvalid", axi_bvalid, 1'b0);
      check("rst_bresp", axi_bresp, 2'b00);
      check("rst_tri_valid", tri_valid, 1'b0);
      check("rst_tri_data", tri_data, 192'd0);
      check("rst_tri_count", tri_count, 16'd0);
      check("rst_busy", busy, 1'b0);
      @(negedge axi_aclk);
      axi_aresetn = 1'b1;
      @(posedge axi_aclk);
      #1;

      // Red triangle, AW and W together
      for (int i = 0; i < 6; i++) axi_write(14'(i * 4), red_w[i], 0, 0);
      check("red_data_literal", tri_data, RED_REC);
      check("red_count", tri_count, 16'd1);

      // Skewed handshakes: AW leads, then W leads
      axi_write(14'h08, 32'h00320078, 0, 3);
      axi_write(14'h04, 32'h008C0099, 3, 0);

      // Unmapped index: SLVERR, nothing changes; then a lone commit reuses shadows
      axi_write(14'h18, 32'hDEADBEEF, 0, 0);
      check("slverr_count", tri_count, 16'd1);
      check("slverr_data", tri_data, RED_REC);
      axi_write(14'h14, 32'h0000068D, 0, 0);

      // Backpressure: A sits in the slot, B stalls until tri_ready
      tri_ready = 1'b0;
      for (int i = 0; i < 6; i++) axi_write(14'(i * 4), a_w[i], 0, 0);
      rec_a = last_rec;
      for (int i = 0; i < 5; i++) axi_write(14'(i * 4), b_w[i], 0, 0);
      do_handshake(14'h14, b_w[5], 0, 0, ok);
      @(negedge axi_aclk);
      check("stall_write_bvalid", axi_bvalid, 1'b0);
      repeat (3) begin
         @(negedge axi_aclk);
         check("stall_busy", busy, 1'b1);
         check("stall_awready", axi_awready, 1'b0);
         check("stall_wready", axi_wready, 1'b0);
         check("stall_bvalid", axi_bvalid, 1'b0);
         check("stall_hold_data", tri_data, rec_a);
      end
      @(posedge axi_aclk);
      #1;
      tri_ready = 1'b1;
      @(posedge axi_aclk);
      #1;
      tri_ready = 1'b0;
      @(negedge axi_aclk);
      check("unstall_bvalid", axi_bvalid, 1'b1);
      check("unstall_busy", busy, 1'b0);
      check("unstall_valid", tri_valid, 1'b1);
      check("unstall_data", tri_data, last_rec);
      check("unstall_count", tri_count, cnt_m);
      @(posedge axi_aclk);
      #1;
      tri_ready = 1'b1;

      // B response held off by bready=0
      axi_bready = 1'b0;
      do_handshake(14'h0C, 32'h00780028, 0, 0, ok);
      @(negedge axi_aclk);
      for (int i = 0; i < 10; i++) begin
         @(negedge axi_aclk);
         check("hold_bvalid", axi_bvalid, 1'b1);
         check("hold_bresp", axi_bresp, 2'b00);
         check("hold_awready", axi_awready, 1'b0);
         check("hold_wready", axi_wready, 1'b0);
      end
      @(posedge axi_aclk);
      #1;
      axi_bready = 1'b1;
      @(posedge axi_aclk);
      #1;
      @(negedge axi_aclk);
      check("hold_done_awready", axi_awready, 1'b1);
      check("hold_done_wready", axi_wready, 1'b1);
      @(posedge axi_aclk);
      #1;

      // Asynchronous reset while stalled
      tri_ready = 1'b0;
      axi_write(14'h14, 32'h12121212, 0, 0);
      do_handshake(14'h14, 32'h34343434, 0, 0, ok);
      @(negedge axi_aclk);
      @(negedge axi_aclk);
      check("pre_reset_busy", busy, 1'b1);
      @(posedge axi_aclk);
      #3;
      axi_aresetn = 1'b0;
      #1;
      check("areset_tri_valid", tri_valid, 1'b0);
      check("areset_bvalid", axi_bvalid, 1'b0);
      check("areset_count", tri_count, 16'd0);
      check("areset_awready", axi_awready, 1'b1);
      check("areset_wready", axi_wready, 1'b1);
      check("areset_busy", busy, 1'b0);
      check("areset_data", tri_data, 192'd0);
      bq.delete();
      rq.delete();
      cnt_m = '0;
      for (int i = 0; i < 5; i++) sh[i] = '0;
      @(negedge axi_aclk);
      axi_aresetn = 1'b1;
      tri_ready   = 1'b1;
      @(posedge axi_aclk);
      #1;
      for (int i = 0; i < 6; i++) axi_write(14'(i * 4), red_w[i], 0, 0);
      check("post_reset_data", tri_data, RED_REC);
      check("post_reset_count", tri_count, 16'd1);

      repeat (3) @(posedge axi_aclk);
      check("bq_drained", bq.size(), 0);
      check("rq_drained", rq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
